ps2_key_decoder: RTL

Parametrised PS/2 scan-code-set-2 decoder that sits between `PS2_Controller` and the game FSMs in the `CLOCK_50` domain. It tracks make, break, extended (E0) and pause (E1) sequences and maps up to `NUM_KEYS` configurable codes to per-key press/release pulses and held levels. This replaces single-byte compares that ignore prefixes, so a release (F0 75) no longer reads as a press. Optionally it generates typematic auto-repeat pulses internally.

---
 rtl/ps2_key_pkg.sv | 28 ++
 rtl/ps2_repeat_timer.sv | 35 +++
 rtl/ps2_key_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_key_pkg.sv
// Shared constants, FSM state type and default key table for the PS/2 set-2 key decoder.
package ps2_key_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Pause is E1 followed by seven more bytes that carry no key information.
  localparam int PAUSE_TAIL_LEN = 7;

  localparam int DEFAULT_NUM_KEYS = 5;
  // ch0 = space, ch1 = right, ch2 = left, ch3 = down, ch4 = up
  localparam logic [DEFAULT_NUM_KEYS*9-1:0] DEFAULT_KEY_CODES =
    {9'h1_75, 9'h1_72, 9'h1_6B, 9'h1_74, 9'h0_29};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// Auto-repeat timer: load starts a DELAY countdown, then fire pulses every PERIOD cycles until clear.
// fire is combinational and suppressed in any cycle that also loads or clears.
module ps2_repeat_timer #(
  parameter int DELAY  = 25_000_000,
  parameter int PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic fire
);

  localparam int MAXV = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int W    = $clog2(MAXV + 1);

  logic         active;
  logic [W-1:0] cnt;

  assign fire = active && (cnt == '0) && !load && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= W'(DELAY - 1);
    end else if (active) begin
      if (cnt == '0) cnt <= W'(PERIOD - 1);
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: tracks E0/F0/E1 sequences and drives per-key press/release pulses and held levels.
// Optional internal auto-repeat is built only when PS2_KEY_AUTOREPEAT_EN is defined.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int                      NUM_KEYS       = DEFAULT_NUM_KEYS,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = DEFAULT_KEY_CODES,
  parameter int                      TIMEOUT_CYCLES = 2_500_000,
  parameter int                      REPEAT_DELAY   = 25_000_000,
  parameter int                      REPEAT_PERIOD  = 5_000_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_press,
  output logic [8:0]          last_code,
  output logic                seq_error
);

  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SKIP_W = $clog2(PAUSE_TAIL_LEN + 1);

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || TIMEOUT_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("ps2_key_decoder: parameter out of range");
  end

  ps2_state_t          state, state_nxt;
  logic [SKIP_W-1:0]   skip_cnt, skip_nxt;
  logic [TMR_W-1:0]    tmr;
  logic                done_make, done_brk, done_ext, err;
  logic [NUM_KEYS-1:0] match, press_nxt, rpt_press;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      tmr      <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      if (rx_valid || state_nxt == ST_IDLE) tmr <= '0;
      else if (tmr != '1)                   tmr <= tmr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    done_make = 1'b0;
    done_brk  = 1'b0;
    done_ext  = 1'b0;
    err       = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == PS2_EXT)        state_nxt = ST_EXT;
          else if (rx_data == PS2_BRK)   state_nxt = ST_BRK;
          else if (rx_data == PS2_PAUSE) begin
            state_nxt = ST_SKIP;
            skip_nxt  = SKIP_W'(PAUSE_TAIL_LEN);
          end else                       done_make = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK)        state_nxt = ST_EXT_BRK;
          else if (rx_data == PS2_EXT)   err = 1'b1;
          else if (rx_data == PS2_PAUSE) begin
            err       = 1'b1;
            state_nxt = ST_SKIP;
            skip_nxt  = SKIP_W'(PAUSE_TAIL_LEN);
          end else begin
            done_make = 1'b1;
            done_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          if (is_prefix(rx_data)) err = 1'b1;
          else begin
            done_brk = 1'b1;
            done_ext = (state == ST_EXT_BRK);
          end
        end
        ST_SKIP: begin
          if (skip_cnt <= SKIP_W'(1)) begin
            state_nxt = ST_IDLE;
            skip_nxt  = '0;
          end else skip_nxt = skip_cnt - 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = ST_IDLE;
      skip_nxt  = '0;
    end
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      match[k] = (KEY_CODES[k*9 +: 9] == {done_ext, rx_data});
  end

`ifdef PS2_KEY_AUTOREPEAT_EN
  logic [NUM_KEYS-1:0] rpt_mask, first_match;
  logic                rpt_load, rpt_clear, rpt_fire;

  // Only a fresh press of the lowest matching channel retargets; keyboard typematic makes do not.
  assign first_match = match & (~match + 1'b1);
  assign rpt_load    = done_make && |(first_match & ~key_held);
  assign rpt_clear   = done_brk && |(match & rpt_mask);
  assign rpt_press   = rpt_fire ? rpt_mask : '0;

  always_ff @(posedge CLOCK_50) begin
    if (reset || rpt_clear) rpt_mask <= '0;
    else if (rpt_load)      rpt_mask <= first_match;
  end

  ps2_repeat_timer #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .clk   (CLOCK_50),
    .reset (reset),
    .load  (rpt_load),
    .clear (rpt_clear),
    .fire  (rpt_fire)
  );
`else
  assign rpt_press = '0;
`endif

  assign press_nxt = (done_make ? (match & ~key_held) : '0) | rpt_press;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_press   <= '0;
      key_release <= '0;
      key_held    <= '0;
      any_press   <= 1'b0;
      last_code   <= 9'h000;
      seq_error   <= 1'b0;
    end else begin
      key_press   <= press_nxt;
      any_press   <= |press_nxt;
      key_release <= done_brk ? match : '0;
      seq_error   <= err;
      if (done_make)     key_held <= key_held | match;
      else if (done_brk) key_held <= key_held & ~match;
      if (done_make || done_brk) last_code <= {done_ext, rx_data};
    end
  end

endmodule
